// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller CPU port and its service
// master: FSM state encoding, register addresses and command bytes.
package int_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG_CMD,
        ST_CFG_DAT,
        ST_ID_CMD,
        ST_ID_RD,
        ST_PRESENT,
        ST_EOI_CMD,
        ST_EOI_DAT
    } state_t;

    // Controller CPU-port register map
    localparam logic REG_CMD  = 1'b0;
    localparam logic REG_DATA = 1'b1;

    // Command bytes understood by the controller
    localparam logic [7:0] CMD_READ_ID = 8'h00; // latch pending id into data reg
    localparam logic [7:0] CMD_EOI     = 8'hff; // next data write retires that id
    localparam logic [7:0] SPURIOUS_ID = 8'hff; // data reg value for "nothing pending"

    // Increment that sticks at all-ones
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/int_service_master_if.sv
// Interface bundling the service master's handshakes and CPU-port bus.
//  cfg_*  : configuration write request (valid/ready)
//  id_*   : serviced IRQ id towards the consumer (valid/ready)
//  bus_*  : controller CPU port, one access per cycle while bus_cs is high
// Handshake rule for both valid/ready pairs: a transfer happens on a rising
// edge where valid and ready are both high; the initiator holds valid and its
// payload stable until that edge.
// Modports: master = int_service_master side, slave = controller/consumer side.
interface int_service_master_if;

    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_cmd;
    logic [7:0] cfg_data;

    logic       id_valid;
    logic       id_ready;
    logic [7:0] id;

    logic       bus_cs;
    logic       bus_rwb;
    logic       bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;

    modport master (
        input  cfg_valid, cfg_cmd, cfg_data, id_ready, bus_rdata,
        output cfg_ready, id_valid, id, bus_cs, bus_rwb, bus_addr, bus_wdata
    );

    modport slave (
        output cfg_valid, cfg_cmd, cfg_data, id_ready, bus_rdata,
        input  cfg_ready, id_valid, id, bus_cs, bus_rwb, bus_addr, bus_wdata
    );

endinterface

// File: rtl/int_bus_driver.sv
// Registered bus front-end for the controller CPU port.
// The FSM presents the access it wants for the *next* cycle on req_*; this
// block flops it so bus_cs/rwb/addr/wdata come straight from registers.
// Read data is handed back unregistered so the FSM can act on it at the edge
// that ends the read cycle.
// Ports:
//  clk, reset_n        clock, async active-low reset
//  req_cs/rwb/addr     next-cycle access request
//  req_wdata           next-cycle write data
//  bus_cs/rwb/addr     registered bus controls (idle: cs=0, rwb=1)
//  bus_wdata           registered write data
//  bus_rdata           read data from the controller
//  rdata               read data towards the FSM
import int_ctrl_pkg::*;

module int_bus_driver (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_cs,
    input  logic       req_rwb,
    input  logic       req_addr,
    input  logic [7:0] req_wdata,
    output logic       bus_cs,
    output logic       bus_rwb,
    output logic       bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    output logic [7:0] rdata
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_cs    <= 1'b0;
            bus_rwb   <= 1'b1;
            bus_addr  <= REG_CMD;
            bus_wdata <= 8'h00;
        end else begin
            bus_cs    <= req_cs;
            bus_rwb   <= req_rwb;
            bus_addr  <= req_addr;
            bus_wdata <= req_wdata;
        end
    end

    assign rdata = bus_rdata;

endmodule

// File: rtl/int_service_master.sv
// Bus initiator for the interrupt controller's 2-register CPU port.
// Performs configuration writes, fetches the pending IRQ id on irq, hands it
// to a consumer and issues end-of-interrupt once the consumer accepts it.
// Ports:
//  clk, reset_n   clock, async active-low reset
//  irq            controller int_out (level, synchronous)
//  port           cfg/id handshakes and CPU-port bus (master modport)
//  spurious_cnt   saturating count of SPURIOUS_ID reads
//  busy           FSM not in IDLE
//  fsm_state      current FSM state, for observation
import int_ctrl_pkg::*;

module int_service_master (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        irq,
    int_service_master_if.master        port,
    output logic [7:0]                  spurious_cnt,
    output logic                        busy,
    output state_t                      fsm_state
);

    state_t     state;
    state_t     next_state;
    logic [7:0] cfg_data_q;
    logic [7:0] id_q;
    logic [7:0] spur_q;
    logic       accept_cfg;
    logic       req_cs;
    logic       req_rwb;
    logic       req_addr;
    logic [7:0] req_wdata;
    logic [7:0] rdata;

    // Next-state logic, then the bus access belonging to the next state so
    // the registered bus shows the access during the state it belongs to.
    always_comb begin
        next_state = state;
        accept_cfg = 1'b0;
        req_cs     = 1'b0;
        req_rwb    = 1'b1;
        req_addr   = REG_CMD;
        req_wdata  = 8'h00;

        case (state)
            ST_IDLE: begin
                // Configuration has priority over interrupt service
                if (port.cfg_valid) begin
                    accept_cfg = 1'b1;
                    next_state = ST_CFG_CMD;
                end else if (irq) begin
                    next_state = ST_ID_CMD;
                end
            end
            ST_CFG_CMD: next_state = ST_CFG_DAT;
            ST_CFG_DAT: next_state = ST_IDLE;
            ST_ID_CMD:  next_state = ST_ID_RD;
            ST_ID_RD:   next_state = (rdata == SPURIOUS_ID) ? ST_IDLE : ST_PRESENT;
            ST_PRESENT: if (port.id_ready) next_state = ST_EOI_CMD;
            ST_EOI_CMD: next_state = ST_EOI_DAT;
            ST_EOI_DAT: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase

        case (next_state)
            ST_CFG_CMD: begin
                // Only reachable from the accept cycle, so the live command
                // byte is the one being accepted.
                req_cs    = 1'b1;
                req_rwb   = 1'b0;
                req_addr  = REG_CMD;
                req_wdata = port.cfg_cmd;
            end
            ST_CFG_DAT: begin
                req_cs    = 1'b1;
                req_rwb   = 1'b0;
                req_addr  = REG_DATA;
                req_wdata = cfg_data_q;
            end
            ST_ID_CMD: begin
                req_cs    = 1'b1;
                req_rwb   = 1'b0;
                req_addr  = REG_CMD;
                req_wdata = CMD_READ_ID;
            end
            ST_ID_RD: begin
                req_cs    = 1'b1;
                req_rwb   = 1'b1;
                req_addr  = REG_DATA;
            end
            ST_EOI_CMD: begin
                req_cs    = 1'b1;
                req_rwb   = 1'b0;
                req_addr  = REG_CMD;
                req_wdata = CMD_EOI;
            end
            ST_EOI_DAT: begin
                req_cs    = 1'b1;
                req_rwb   = 1'b0;
                req_addr  = REG_DATA;
                req_wdata = id_q;
            end
            default: begin
                req_cs    = 1'b0;
                req_rwb   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Data-path registers: configuration data, fetched id, spurious count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_data_q <= 8'h00;
            id_q       <= 8'h00;
            spur_q     <= 8'h00;
        end else begin
            if (accept_cfg) begin
                cfg_data_q <= port.cfg_data;
            end
            if (state == ST_ID_RD) begin
                if (rdata == SPURIOUS_ID) begin
                    spur_q <= sat_inc(spur_q);
                end else begin
                    id_q <= rdata;
                end
            end
        end
    end

    int_bus_driver u_bus (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_cs    (req_cs),
        .req_rwb   (req_rwb),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .bus_cs    (port.bus_cs),
        .bus_rwb   (port.bus_rwb),
        .bus_addr  (port.bus_addr),
        .bus_wdata (port.bus_wdata),
        .bus_rdata (port.bus_rdata),
        .rdata     (rdata)
    );

    assign port.cfg_ready = accept_cfg;
    assign port.id_valid  = (state == ST_PRESENT);
    assign port.id        = id_q;
    assign spurious_cnt   = spur_q;
    assign busy           = (state != ST_IDLE);
    assign fsm_state      = state;

endmodule

// File: tb/tb_int_service_master.sv
// Testbench for int_service_master: a controller model answers reads from
// rd_val, a bus monitor pops expected accesses from exp_q on every bus cycle,
// and scenario tasks check handshake timing and status outputs inline.
import int_ctrl_pkg::*;

module tb_int_service_master;

    logic       clk;
    logic       reset_n;
    logic       irq;
    logic [7:0] spurious_cnt;
    logic       busy;
    state_t     fsm_state;
    logic [7:0] rd_val;

    int total;
    int bad;
    int cfg_ready_cnt;

    // Expected bus accesses: {rwb, addr, data}; data is 0 for reads
    logic [9:0] exp_q[$];
    logic [9:0] obs;
    logic [9:0] exp_v;

    int_service_master_if ifc ();

    int_service_master dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .irq          (irq),
        .port         (ifc.master),
        .spurious_cnt (spurious_cnt),
        .busy         (busy),
        .fsm_state    (fsm_state)
    );

    // Controller model: data register returns rd_val during a read of addr 1
    assign ifc.bus_rdata = (ifc.bus_cs && ifc.bus_rwb && ifc.bus_addr) ? rd_val : 8'h00;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bus monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset_n && ifc.bus_cs) begin
            obs = {ifc.bus_rwb, ifc.bus_addr, ifc.bus_rwb ? 8'h00 : ifc.bus_wdata};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL bus_access unexpected: got=%h required=none", obs);
            end else begin
                exp_v = exp_q.pop_front();
                if (obs !== exp_v) begin
                    bad++;
                    $display("FAIL bus_access: got=%h required=%h", obs, exp_v);
                end
            end
        end
        if (reset_n && ifc.cfg_ready) cfg_ready_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input logic addr, input logic [7:0] data);
        exp_q.push_back({1'b0, addr, data});
    endtask

    task automatic push_r();
        exp_q.push_back({1'b1, 1'b1, 8'h00});
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        irq = 1'b0;
        ifc.cfg_valid = 1'b0;
        ifc.cfg_cmd = 8'h00;
        ifc.cfg_data = 8'h00;
        ifc.id_ready = 1'b0;
        rd_val = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ifc.bus_cs, ifc.bus_rwb, ifc.id_valid, ifc.cfg_ready, busy} !== 5'b01000) begin
            bad++;
            $display("FAIL reset_outputs: got cs,rwb,idv,cfgr,busy=%b required=01000",
                     {ifc.bus_cs, ifc.bus_rwb, ifc.id_valid, ifc.cfg_ready, busy});
        end
        total++;
        if ({spurious_cnt, ifc.id, ifc.bus_wdata} !== 24'h0) begin
            bad++;
            $display("FAIL reset_regs: got spur=%h id=%h wdata=%h required=0",
                     spurious_cnt, ifc.id, ifc.bus_wdata);
        end
        reset_n = 1'b1;
        tick();
        // Abort in the middle of an id fetch
        rd_val = 8'h05;
        irq = 1'b1;
        push_w(REG_CMD, CMD_READ_ID);
        tick();
        tick();
        total++;
        if (fsm_state !== ST_ID_RD) begin
            bad++;
            $display("FAIL reset_pre_state: got=%0d required=%0d", fsm_state, ST_ID_RD);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({ifc.bus_cs, ifc.bus_rwb, ifc.id_valid} !== 3'b010 || fsm_state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_abort: got cs,rwb,idv=%b state=%0d required=010 state=0",
                     {ifc.bus_cs, ifc.bus_rwb, ifc.id_valid}, fsm_state);
        end
        irq = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        total++;
        if (fsm_state !== ST_IDLE || ifc.bus_cs !== 1'b0 || spurious_cnt !== 8'h00) begin
            bad++;
            $display("FAIL reset_release: got state=%0d cs=%b spur=%h required IDLE,0,00",
                     fsm_state, ifc.bus_cs, spurious_cnt);
        end
    endtask

    task automatic test_config();
        int cnt0;
        cnt0 = cfg_ready_cnt;
        ifc.id_ready = 1'b1; // must be ignored outside PRESENT
        ifc.cfg_cmd = 8'h10;
        ifc.cfg_data = 8'hff;
        ifc.cfg_valid = 1'b1;
        #1;
        total++;
        if (ifc.cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL cfg_ready_idle: got=%b required=1", ifc.cfg_ready);
        end
        push_w(REG_CMD, 8'h10);
        push_w(REG_DATA, 8'hff);
        tick();
        ifc.cfg_valid = 1'b0;
        ifc.cfg_cmd = 8'h00;
        ifc.cfg_data = 8'h00;
        total++;
        if (fsm_state !== ST_CFG_CMD || ifc.bus_wdata !== 8'h10) begin
            bad++;
            $display("FAIL cfg_cmd_cycle: got state=%0d wdata=%h required=%0d,10",
                     fsm_state, ifc.bus_wdata, ST_CFG_CMD);
        end
        tick();
        total++;
        if (ifc.bus_addr !== 1'b1 || ifc.bus_wdata !== 8'hff || ifc.bus_cs !== 1'b1) begin
            bad++;
            $display("FAIL cfg_dat_cycle: got cs=%b addr=%b wdata=%h required 1,1,ff",
                     ifc.bus_cs, ifc.bus_addr, ifc.bus_wdata);
        end
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || cfg_ready_cnt - cnt0 !== 1) begin
            bad++;
            $display("FAIL cfg_done: got busy=%b ready_pulses=%0d required 0,1",
                     busy, cfg_ready_cnt - cnt0);
        end
        ifc.id_ready = 1'b0;
    endtask

    task automatic test_service();
        rd_val = 8'h05;
        irq = 1'b1;
        push_w(REG_CMD, CMD_READ_ID);
        push_r();
        tick();
        total++;
        if (ifc.id_valid !== 1'b0 || fsm_state !== ST_ID_CMD) begin
            bad++;
            $display("FAIL svc_cycle1: got idv=%b state=%0d required 0,%0d",
                     ifc.id_valid, fsm_state, ST_ID_CMD);
        end
        tick();
        total++;
        if (ifc.id_valid !== 1'b0 || ifc.bus_rwb !== 1'b1 || ifc.bus_addr !== 1'b1) begin
            bad++;
            $display("FAIL svc_cycle2: got idv=%b rwb=%b addr=%b required 0,1,1",
                     ifc.id_valid, ifc.bus_rwb, ifc.bus_addr);
        end
        tick();
        total++;
        if (ifc.id_valid !== 1'b1 || ifc.id !== 8'h05) begin
            bad++;
            $display("FAIL svc_present: got idv=%b id=%h required 1,05", ifc.id_valid, ifc.id);
        end
        irq = 1'b0;
        tick();
        total++;
        if (ifc.id_valid !== 1'b1 || ifc.id !== 8'h05) begin
            bad++;
            $display("FAIL svc_hold: got idv=%b id=%h required 1,05", ifc.id_valid, ifc.id);
        end
        ifc.id_ready = 1'b1;
        push_w(REG_CMD, CMD_EOI);
        push_w(REG_DATA, 8'h05);
        tick();
        ifc.id_ready = 1'b0;
        total++;
        if (ifc.id_valid !== 1'b0 || fsm_state !== ST_EOI_CMD) begin
            bad++;
            $display("FAIL svc_eoi_cmd: got idv=%b state=%0d required 0,%0d",
                     ifc.id_valid, fsm_state, ST_EOI_CMD);
        end
        tick();
        total++;
        if (fsm_state !== ST_EOI_DAT || ifc.bus_wdata !== 8'h05) begin
            bad++;
            $display("FAIL svc_eoi_dat: got state=%0d wdata=%h required %0d,05",
                     fsm_state, ifc.bus_wdata, ST_EOI_DAT);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL svc_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_spurious();
        logic saw_valid;
        saw_valid = 1'b0;
        rd_val = SPURIOUS_ID;
        for (int i = 0; i < 300; i++) begin
            push_w(REG_CMD, CMD_READ_ID);
            push_r();
            irq = 1'b1;
            tick();
            irq = 1'b0; // dropping mid-fetch still completes the sequence
            saw_valid |= ifc.id_valid;
            tick();
            saw_valid |= ifc.id_valid;
            tick();
            saw_valid |= ifc.id_valid;
            if (i == 0 || i == 253 || i == 254 || i == 299) begin
                total++;
                if (spurious_cnt !== ((i >= 254) ? 8'hff : 8'(i + 1))) begin
                    bad++;
                    $display("FAIL spur_count[%0d]: got=%h required=%h", i, spurious_cnt,
                             (i >= 254) ? 8'hff : 8'(i + 1));
                end
            end
        end
        total++;
        if (saw_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL spur_no_id: got saw_valid=%b busy=%b required 0,0", saw_valid, busy);
        end
    endtask

    task automatic test_collision();
        int cnt0;
        rd_val = 8'h2a;
        ifc.cfg_cmd = 8'h21;
        ifc.cfg_data = 8'h3c;
        ifc.cfg_valid = 1'b1;
        irq = 1'b1;
        push_w(REG_CMD, 8'h21);
        push_w(REG_DATA, 8'h3c);
        push_w(REG_CMD, CMD_READ_ID);
        push_r();
        tick();
        ifc.cfg_valid = 1'b0;
        total++;
        if (fsm_state !== ST_CFG_CMD) begin
            bad++;
            $display("FAIL coll_cfg_first: got state=%0d required=%0d", fsm_state, ST_CFG_CMD);
        end
        tick();
        tick();
        tick();
        total++;
        if (fsm_state !== ST_ID_CMD) begin
            bad++;
            $display("FAIL coll_then_id: got state=%0d required=%0d", fsm_state, ST_ID_CMD);
        end
        tick();
        tick();
        irq = 1'b0;
        total++;
        if (ifc.id_valid !== 1'b1 || ifc.id !== 8'h2a) begin
            bad++;
            $display("FAIL coll_present: got idv=%b id=%h required 1,2a", ifc.id_valid, ifc.id);
        end
        // Config request while an id is outstanding must wait
        cnt0 = cfg_ready_cnt;
        ifc.cfg_cmd = 8'h20;
        ifc.cfg_data = 8'h0f;
        ifc.cfg_valid = 1'b1;
        tick();
        tick();
        ifc.id_ready = 1'b1;
        push_w(REG_CMD, CMD_EOI);
        push_w(REG_DATA, 8'h2a);
        tick();
        ifc.id_ready = 1'b0;
        tick();
        total++;
        if (cfg_ready_cnt !== cnt0 || fsm_state !== ST_EOI_DAT) begin
            bad++;
            $display("FAIL coll_stall: got pulses=%0d state=%0d required 0,%0d",
                     cfg_ready_cnt - cnt0, fsm_state, ST_EOI_DAT);
        end
        tick();
        total++;
        if (ifc.cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL coll_accept: got cfg_ready=%b required 1", ifc.cfg_ready);
        end
        push_w(REG_CMD, 8'h20);
        push_w(REG_DATA, 8'h0f);
        tick();
        ifc.cfg_valid = 1'b0;
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || cfg_ready_cnt - cnt0 !== 1) begin
            bad++;
            $display("FAIL coll_done: got busy=%b pulses=%0d required 0,1",
                     busy, cfg_ready_cnt - cnt0);
        end
    endtask

    task automatic test_back_to_back();
        rd_val = 8'h03;
        irq = 1'b1;
        push_w(REG_CMD, CMD_READ_ID);
        push_r();
        tick();
        tick();
        tick();
        total++;
        if (ifc.id_valid !== 1'b1 || ifc.id !== 8'h03) begin
            bad++;
            $display("FAIL b2b_first: got idv=%b id=%h required 1,03", ifc.id_valid, ifc.id);
        end
        ifc.id_ready = 1'b1;
        rd_val = 8'h07;
        push_w(REG_CMD, CMD_EOI);
        push_w(REG_DATA, 8'h03);
        push_w(REG_CMD, CMD_READ_ID);
        push_r();
        tick();
        ifc.id_ready = 1'b0;
        tick();
        tick();
        total++;
        if (fsm_state !== ST_IDLE) begin
            bad++;
            $display("FAIL b2b_idle: got state=%0d required=%0d", fsm_state, ST_IDLE);
        end
        tick();
        total++;
        if (fsm_state !== ST_ID_CMD) begin
            bad++;
            $display("FAIL b2b_reenter: got state=%0d required=%0d", fsm_state, ST_ID_CMD);
        end
        tick();
        tick();
        irq = 1'b0;
        total++;
        if (ifc.id_valid !== 1'b1 || ifc.id !== 8'h07) begin
            bad++;
            $display("FAIL b2b_second: got idv=%b id=%h required 1,07", ifc.id_valid, ifc.id);
        end
        ifc.id_ready = 1'b1;
        push_w(REG_CMD, CMD_EOI);
        push_w(REG_DATA, 8'h07);
        tick();
        ifc.id_ready = 1'b0;
        tick();
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done: got busy=%b required 0", busy);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total = 0;
        bad = 0;
        cfg_ready_cnt = 0;
        test_reset();
        test_config();
        test_service();
        test_spurious();
        test_collision();
        test_back_to_back();
        repeat (3) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending accesses required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
